// File: rtl/light_dance_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : light_dance_ctrl
//  Description : Step-rate sequencer and round-robin seed arbiter that drives
//                the load/pdata/din inputs of the LightDance pattern register.
//  Revision    : 1.0 - initial release
// ============================================================================
module light_dance_ctrl #(
    parameter int          N_REQ        = 4,
    parameter int          DIV_W        = 16,
    parameter logic [7:0]  SEED_DEFAULT = 8'h01
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 en,
    input  logic [DIV_W-1:0]     period,
    input  logic                 din_ext,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   seed_in,
    input  logic [7:0]           qdata,
    output logic [N_REQ-1:0]     gnt,
    output logic                 load,
    output logic [7:0]           pdata,
    output logic                 din,
    output logic                 step,
    output logic [1:0]           state
);

    localparam int         c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEED  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [c_PTR_W-1:0] r_rr_ptr;

    logic [1:0]         w_state_nxt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [c_PTR_W-1:0] w_rr_nxt;

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [N_REQ-1:0]   w_first_rot;
    logic [2*N_REQ-1:0] w_onehot_dbl;
    logic [N_REQ-1:0]   w_arb_onehot;
    logic               w_any_req;

    logic [c_PTR_W-1:0] w_gnt_idx;
    logic [7:0]         w_seed_sel;
    logic [7:0]         w_seed_eff;
    logic [c_PTR_W-1:0] w_rr_after;

    // Rotate requests so rr_ptr sits at bit 0, isolate the lowest set bit,
    // then rotate that single bit back into absolute position.
    assign w_any_req    = |req;
    assign w_req_dbl    = {req, req} >> r_rr_ptr;
    assign w_req_rot    = w_req_dbl[N_REQ-1:0];
    assign w_first_rot  = w_req_rot & (-w_req_rot);
    assign w_onehot_dbl = {w_first_rot, w_first_rot} << r_rr_ptr;
    assign w_arb_onehot = w_onehot_dbl[2*N_REQ-1:N_REQ];

    always_comb begin
        w_gnt_idx  = '0;
        w_seed_sel = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_gnt_idx  = c_PTR_W'(i);
                w_seed_sel = seed_in[8*i +: 8];
            end
        end
    end

    assign w_seed_eff = (w_seed_sel == 8'h00) ? SEED_DEFAULT : w_seed_sel;
    assign w_rr_after = (w_gnt_idx == c_PTR_W'(N_REQ-1)) ? '0 : w_gnt_idx + c_PTR_W'(1);
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr_ptr;
        load        = 1'b1;
        pdata       = qdata;
        din         = 1'b0;
        step        = 1'b0;
        gnt         = '0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_gnt_nxt   = w_arb_onehot;
                    w_state_nxt = S_SEED;
                end else if (en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end

            S_SEED: begin
                pdata       = w_seed_eff;
                gnt         = r_gnt;
                w_rr_nxt    = w_rr_after;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = '0;
                w_state_nxt = en ? S_RUN : S_IDLE;
            end

            S_RUN: begin
                // A count already past a lowered period runs on and wraps
                // rather than forcing an early step.
                if (r_cnt == period) begin
                    load      = 1'b0;
                    din       = din_ext;
                    step      = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
                if (w_any_req) begin
                    w_gnt_nxt   = w_arb_onehot;
                    w_state_nxt = S_SEED;
                end else if (!en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Reset overrides everything so a SEED cycle cut by reset never loads.
        if (arst) begin
            load  = 1'b1;
            pdata = qdata;
            din   = 1'b0;
            step  = 1'b0;
            gnt   = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_light_dance_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_dance_ctrl
//  Description : Directed self-checking bench for light_dance_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_light_dance_ctrl;

    localparam int N_REQ = 4;
    localparam int DIV_W = 16;

    logic                 clk = 1'b0;
    logic                 arst;
    logic                 en;
    logic [DIV_W-1:0]     period;
    logic                 din_ext;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   seed_in;
    logic [7:0]           qdata;
    logic [N_REQ-1:0]     gnt;
    logic                 load;
    logic [7:0]           pdata;
    logic                 din;
    logic                 step;
    logic [1:0]           state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_g [4];
    logic [31:0] exp_p [4];

    always #5 clk = ~clk;

    light_dance_ctrl #(
        .N_REQ        (N_REQ),
        .DIV_W        (DIV_W),
        .SEED_DEFAULT (8'h01)
    ) dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .period  (period),
        .din_ext (din_ext),
        .req     (req),
        .seed_in (seed_in),
        .qdata   (qdata),
        .gnt     (gnt),
        .load    (load),
        .pdata   (pdata),
        .din     (din),
        .step    (step),
        .state   (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_g = '{32'h1, 32'h2, 32'h8, 32'h1};
        exp_p = '{32'h01, 32'h3C, 32'hD4, 32'h01};

        arst = 1'b1; en = 1'b0; period = '0; din_ext = 1'b0;
        req = '0; seed_in = '0; qdata = 8'hA5;
        nxt(); nxt(); #2;
        chk("rst_load",  32'(load),  1);
        chk("rst_pdata", 32'(pdata), 'hA5);
        chk("rst_gnt",   32'(gnt),   0);
        chk("rst_step",  32'(step),  0);
        chk("rst_state", 32'(state), 0);

        // Single seed request while frozen
        arst = 1'b0; req = 4'b0010; seed_in[15:8] = 8'h3C; #2;
        chk("idle_state", 32'(state), 0);
        chk("idle_gnt",   32'(gnt),   0);
        nxt(); req = '0; #2;
        chk("seed_state", 32'(state), 1);
        chk("seed_gnt",   32'(gnt),   'h2);
        chk("seed_load",  32'(load),  1);
        chk("seed_pdata", 32'(pdata), 'h3C);
        nxt(); #2;
        chk("post_seed_state", 32'(state), 0);
        chk("post_seed_gnt",   32'(gnt),   0);
        chk("post_seed_pdata", 32'(pdata), 'hA5);

        // Stepping with period=3, then period=0
        en = 1'b1; period = 16'd3; din_ext = 1'b1; #2;
        chk("idle_en_step", 32'(step), 0);
        nxt();
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("run_state", 32'(state), 2);
            chk("run_step",  32'(step), (k % 4 == 3) ? 1 : 0);
            chk("run_load",  32'(load), (k % 4 == 3) ? 0 : 1);
            chk("run_din",   32'(din),  (k % 4 == 3) ? 1 : 0);
            nxt();
        end
        period = '0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("p0_step", 32'(step), 1);
            chk("p0_load", 32'(load), 0);
            nxt();
        end

        // en drop at cnt=2, then restart and confirm count starts at 0
        period = 16'd3; #2;
        chk("cnt0_step", 32'(step), 0);
        nxt(); nxt();
        en = 1'b0; #2;
        chk("cnt2_step",  32'(step),  0);
        chk("cnt2_state", 32'(state), 2);
        nxt(); #2;
        chk("stop_state", 32'(state), 0);
        chk("stop_load",  32'(load),  1);
        en = 1'b1;
        nxt();
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("restart_step", 32'(step), (k == 3) ? 1 : 0);
            nxt();
        end

        // Reset to rr_ptr=0, then round-robin with held requests
        en = 1'b0; arst = 1'b1;
        nxt();
        arst = 1'b0;
        seed_in = {8'hD4, 8'h77, 8'h3C, 8'h00};
        req = 4'b1011; #2;
        chk("rr_idle_state", 32'(state), 0);
        for (int g = 0; g < 4; g++) begin
            nxt(); #2;
            chk("rr_seed_state", 32'(state), 1);
            chk("rr_gnt",        32'(gnt),   exp_g[g]);
            chk("rr_pdata",      32'(pdata), exp_p[g]);
            nxt(); #2;
            chk("rr_gap_state", 32'(state), 0);
            chk("rr_gap_gnt",   32'(gnt),   0);
        end
        req = '0;

        // Reset arriving during a SEED cycle
        req = 4'b0100;
        nxt();
        arst = 1'b1; req = '0; #2;
        chk("rstseed_load",  32'(load),  1);
        chk("rstseed_pdata", 32'(pdata), 'hA5);
        chk("rstseed_gnt",   32'(gnt),   0);
        chk("rstseed_step",  32'(step),  0);
        nxt(); arst = 1'b0; #2;
        chk("rstseed_state", 32'(state), 0);
        req = 4'b1111;
        nxt(); #2;
        chk("rstseed_rr_gnt", 32'(gnt), 'h1);
        req = '0;
        nxt();

        // Request arriving in a RUN step cycle
        en = 1'b1; period = '0;
        nxt();
        req = 4'b1000; #2;
        chk("runreq_step",  32'(step),  1);
        chk("runreq_state", 32'(state), 2);
        nxt(); req = '0; #2;
        chk("runreq_seed_state", 32'(state), 1);
        chk("runreq_gnt",        32'(gnt),   'h8);
        chk("runreq_pdata",      32'(pdata), 'hD4);
        nxt(); #2;
        chk("runreq_back_state", 32'(state), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
